complex_pair_assembler: RTL and testbench

//   Receive end of the complex component stream: takes single 32-bit components

---
 rtl/complex_pkg.sv | 20 ++
 rtl/cplx_fifo.sv | 68 ++++++
 rtl/complex_pair_assembler.sv | 102 ++++++++++
 tb/tb_complex_pair_assembler.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/complex_pkg.sv
// Shared types for the complex component stream: pair word, component tag,
// and the pair assembler state encoding.
package complex_pkg;

    typedef enum logic {
        RE = 1'b0,
        IM = 1'b1
    } c_type_t;

    typedef struct packed {
        logic signed [31:0] x;
        logic signed [31:0] y;
    } c_t;

    typedef enum logic {
        WAIT_RE = 1'b0,
        WAIT_IM = 1'b1
    } asm_state_t;

endpackage

// File: rtl/cplx_fifo.sv
// Synchronous FIFO of c_t words with full/empty flags; head is read straight
// from the registered storage so it is stable for the whole cycle.
module cplx_fifo
    import complex_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  c_t   push_data,
    input  logic pop,
    output c_t   head,
    output logic full,
    output logic empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    c_t            mem_q [DEPTH];
    c_t            mem_d [DEPTH];
    logic          do_push;
    logic          do_pop;

    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == '0);
    assign head  = mem_q[rd_ptr_q];

    always_comb begin
        do_push  = push & ~full;
        do_pop   = pop & ~empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        mem_d    = mem_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            mem_q    <= '{default: '0};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/complex_pair_assembler.sv
// Pairs RE/IM tagged components into c_t words, buffers them in a small FIFO,
// flags out-of-order components and counts delivered pairs.
module complex_pair_assembler
    import complex_pkg::*;
#(
    parameter int unsigned OUT_DEPTH = 2,
    parameter int unsigned CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  c_type_t           in_type,
    input  logic [31:0]       in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output c_t                out_c,
    output logic              err_order,
    output logic [CNT_W-1:0]  pair_cnt
);

    asm_state_t         state_q, state_d;
    logic [31:0]        x_q, x_d;
    logic               err_q, err_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               in_fire;
    logic               out_fire;
    logic               push;
    c_t                 push_data;
    logic               fifo_full;
    logic               fifo_empty;

    // An RE is always acceptable in WAIT_RE since it only loads the holding register.
    assign in_ready  = (state_q == WAIT_RE) | ~fifo_full;
    assign in_fire   = in_valid & in_ready;
    assign out_valid = ~fifo_empty;
    assign out_fire  = out_valid & out_ready;
    assign err_order = err_q;
    assign pair_cnt  = cnt_q;
    assign push_data = '{x: x_q, y: in_data};

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        err_d   = 1'b0;
        push    = 1'b0;
        if (in_fire) begin
            case (state_q)
                WAIT_RE: begin
                    if (in_type == RE) begin
                        x_d     = in_data;
                        state_d = WAIT_IM;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                WAIT_IM: begin
                    if (in_type == IM) begin
                        push    = 1'b1;
                        state_d = WAIT_RE;
                    end else begin
                        x_d   = in_data;
                        err_d = 1'b1;
                    end
                end
                default: state_d = WAIT_RE;
            endcase
        end
        cnt_d = cnt_q;
        if (out_fire && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= WAIT_RE;
            x_q     <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    cplx_fifo #(
        .DEPTH(OUT_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_data),
        .pop       (out_ready),
        .head      (out_c),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule

// File: tb/tb_complex_pair_assembler.sv
// Directed bench for complex_pair_assembler: ordering errors, backpressure,
// streaming throughput, mid-pair reset and counter saturation.
module tb_complex_pair_assembler;
    import complex_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    c_type_t     in_type;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    c_t          out_c;
    logic        err_order;
    logic [15:0] pair_cnt;

    logic        s_in_ready;
    logic        s_out_valid;
    c_t          s_out_c;
    logic        s_err_order;
    logic [1:0]  s_pair_cnt;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    int unsigned err_cnt = 0;
    int unsigned cyc = 0;
    c_t          got[$];
    c_t          exp_q[$];
    logic        rnd_done;

    always #5 clk = ~clk;

    complex_pair_assembler #(.OUT_DEPTH(2), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_type(in_type), .in_data(in_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_c(out_c), .err_order(err_order),
        .pair_cnt(pair_cnt)
    );

    complex_pair_assembler #(.OUT_DEPTH(2), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_type(in_type), .in_data(in_data), .out_valid(s_out_valid),
        .out_ready(out_ready), .out_c(s_out_c), .err_order(s_err_order),
        .pair_cnt(s_pair_cnt)
    );

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst) begin
            if (err_order) err_cnt++;
            if (out_valid && out_ready) got.push_back(out_c);
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, expv);
        end
    endtask

    function automatic c_t mk(input int a, input int b);
        return '{x: a, y: b};
    endfunction

    task automatic step(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        got.delete();
        exp_q.delete();
        err_cnt = 0;
    endtask

    task automatic send(input c_type_t t, input logic [31:0] d);
        int unsigned waits = 0;
        in_valid = 1'b1;
        in_type  = t;
        in_data  = d;
        while (!in_ready && waits < 50) begin
            @(posedge clk);
            #1;
            waits++;
        end
        if (!in_ready) begin
            check("send_timeout", 64'(in_ready), 64'd1);
        end else begin
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic send_pair(input int a, input int b);
        send(RE, a);
        send(IM, b);
        exp_q.push_back(mk(a, b));
    endtask

    task automatic check_stream(input string tag);
        check({tag, "_count"}, 64'(got.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got.size(); i++)
            check(tag, got[i], exp_q[i]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned t0;
        logic [15:0] pat;
        rst       = 1'b0;
        in_valid  = 1'b0;
        in_type   = RE;
        in_data   = '0;
        out_ready = 1'b1;
        rnd_done  = 1'b0;
        pat       = 16'hB38D;
        step(2);

        // Reset values and basic pair
        do_reset();
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_c", out_c, 64'd0);
        check("rst_err", 64'(err_order), 64'd0);
        check("rst_cnt", 64'(pair_cnt), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        send(RE, 32'd3);
        send(IM, 32'd7);
        check("t1_valid", 64'(out_valid), 64'd1);
        check("t1_out_c", out_c, mk(3, 7));
        step(1);
        check("t1_cnt", 64'(pair_cnt), 64'd1);
        check("t1_empty", 64'(out_valid), 64'd0);
        check("t1_err", 64'(err_cnt), 64'd0);

        // IM first is dropped
        do_reset();
        send(IM, 32'd5);
        step(2);
        check("t2_err", 64'(err_cnt), 64'd1);
        check("t2_no_out", 64'(got.size()), 64'd0);
        send(RE, 32'd1);
        send(IM, 32'd2);
        check("t2_out_c", out_c, mk(1, 2));
        step(1);
        check("t2_cnt", 64'(pair_cnt), 64'd1);

        // RE overwrite
        do_reset();
        send(RE, 32'd1);
        send(RE, 32'd9);
        send(IM, 32'd4);
        check("t3_out_c", out_c, mk(9, 4));
        step(2);
        check("t3_err", 64'(err_cnt), 64'd1);

        // Backpressure with depth-2 FIFO
        do_reset();
        out_ready = 1'b0;
        send_pair(32'hA0, -32'sd1);
        send_pair(32'hB0, 32'hB1);
        send(RE, 32'hC0);
        check("t4_in_ready_low", 64'(in_ready), 64'd0);
        step(2);
        check("t4_held_head", out_c, mk(32'hA0, -1));
        check("t4_held_valid", 64'(out_valid), 64'd1);
        out_ready = 1'b1;
        send(IM, 32'hC1);
        exp_q.push_back(mk(32'hC0, 32'hC1));
        step(4);
        check_stream("t4_order");
        check("t4_cnt", 64'(pair_cnt), 64'd3);

        // Streaming throughput: 4 pairs in 8 cycles
        do_reset();
        t0 = cyc;
        for (int i = 0; i < 4; i++) send_pair(100 + i, -200 - i);
        check("t5_cycles", 64'(cyc - t0), 64'd8);
        step(2);
        check_stream("t5_stream");

        // Irregular out_ready
        do_reset();
        rnd_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 6; i++) send_pair(i * 17, 1000 - i);
                rnd_done = 1'b1;
            end
            begin
                for (int unsigned k = 0; !rnd_done; k++) begin
                    out_ready = pat[k % 16];
                    @(posedge clk);
                    #1;
                end
            end
        join
        out_ready = 1'b1;
        step(4);
        check_stream("t5_rand");
        check("t5_rand_cnt", 64'(pair_cnt), 64'd6);

        // Reset mid-pair, then saturation
        do_reset();
        send(RE, 32'd11);
        do_reset();
        send(IM, 32'd12);
        step(2);
        check("t6_err", 64'(err_cnt), 64'd1);
        check("t6_no_out", 64'(got.size()), 64'd0);
        check("t6_cnt", 64'(pair_cnt), 64'd0);
        for (int i = 0; i < 5; i++) send_pair(i, i + 50);
        step(2);
        check_stream("t6_stream");
        check("t6_cnt5", 64'(pair_cnt), 64'd5);
        check("t6_sat", 64'(s_pair_cnt), 64'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
